// File: rtl/ula_seq.sv
// Handshaked ALU with registered result/flags and an iterative shift-add multiplier.
// Single-cycle ops complete at the accept edge; MUL finishes WIDTH cycles later.
`timescale 1ns/1ps
module ula_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       F,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Resultado,
    output logic             Zero,
    output logic             Overflow,
    output logic             Negativo,
    output logic             Carry
);

    // state     | meaning
    // S_IDLE    | waiting for an operation; output register may hold a result
    // S_MUL_RUN | shift-add multiply in progress, WIDTH iterations
    typedef enum logic {S_IDLE, S_MUL_RUN} state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam int W2 = 2 * WIDTH;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;

    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d, ovf_q, ovf_d, neg_q, neg_d, carry_q, carry_d;
    logic [W2-1:0]    mcand_q, mcand_d, acc_q, acc_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] b_op, alu_res;
    logic [WIDTH:0]   sum;
    logic             alu_c, alu_v, accept;
    logic [W2-1:0]    mul_sum;

    assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        b_op    = F[0] ? ~B : B;
        sum     = {1'b0, A} + {1'b0, b_op} + {{WIDTH{1'b0}}, F[0]};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (F)
            OP_ADD, OP_SUB: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = ~(A[WIDTH-1] ^ B[WIDTH-1] ^ F[0]) & (A[WIDTH-1] ^ sum[WIDTH-1]);
            end
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_MUL:  alu_res = '0;
            default: alu_res = ~(A | B);
        endcase
    end

    assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        res_d       = res_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        neg_d       = neg_q;
        carry_d     = carry_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (F == OP_MUL) begin
                        mcand_d  = {{WIDTH{1'b0}}, A};
                        mplier_d = B;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = S_MUL_RUN;
                    end else begin
                        res_d       = alu_res;
                        carry_d     = alu_c;
                        ovf_d       = alu_v;
                        zero_d      = (alu_res == '0);
                        neg_d       = alu_res[WIDTH-1];
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_MUL_RUN: begin
                acc_d    = mul_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    res_d       = mul_sum[WIDTH-1:0];
                    carry_d     = (mul_sum[W2-1:WIDTH] != '0);
                    ovf_d       = 1'b0;
                    zero_d      = (mul_sum[WIDTH-1:0] == '0);
                    neg_d       = mul_sum[WIDTH-1];
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            neg_q       <= 1'b0;
            carry_q     <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            neg_q       <= neg_d;
            carry_q     <= carry_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign Resultado = res_q;
    assign Zero      = zero_q;
    assign Overflow  = ovf_q;
    assign Negativo  = neg_q;
    assign Carry     = carry_q;

endmodule

// File: tb/tb_ula_seq.sv
// Directed bench for ula_seq: a 32-bit and an 8-bit instance share clock and reset.
`timescale 1ns/1ps
module tb_ula_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        iv32 = 1'b0, ir32, ov32, ordy32 = 1'b1, z32, v32, n32, c32;
    logic [31:0] a32 = '0, b32 = '0, res32;
    logic [2:0]  f32 = '0;

    logic        iv8 = 1'b0, ir8, ov8, ordy8 = 1'b1, z8, v8, n8, c8;
    logic [7:0]  a8 = '0, b8 = '0, res8;
    logic [2:0]  f8 = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ula_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
        .A(a32), .B(b32), .F(f32), .out_valid(ov32), .out_ready(ordy32),
        .Resultado(res32), .Zero(z32), .Overflow(v32), .Negativo(n32), .Carry(c32)
    );

    ula_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .A(a8), .B(b8), .F(f8), .out_valid(ov8), .out_ready(ordy8),
        .Resultado(res8), .Zero(z8), .Overflow(v8), .Negativo(n8), .Carry(c8)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic op32(input logic [2:0] op, input logic [31:0] a_v, input logic [31:0] b_v);
        #1;
        check_val("ready32_before_issue", 64'(ir32), 64'h1);
        iv32 = 1'b1; a32 = a_v; b32 = b_v; f32 = op;
        @(posedge clk); #1;
        iv32 = 1'b0;
    endtask

    task automatic op8(input logic [2:0] op, input logic [7:0] a_v, input logic [7:0] b_v);
        #1;
        check_val("ready8_before_issue", 64'(ir8), 64'h1);
        iv8 = 1'b1; a8 = a_v; b8 = b_v; f8 = op;
        @(posedge clk); #1;
        iv8 = 1'b0;
    endtask

    // Count cycles from the accept edge until out_valid rises (bounded).
    task automatic wait_out32(output int cyc, output int rdy_bad);
        cyc = 0; rdy_bad = 0;
        while (!ov32 && cyc < 200) begin
            if (ir32) rdy_bad++;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic wait_out8(output int cyc, output int rdy_bad);
        cyc = 0; rdy_bad = 0;
        while (!ov8 && cyc < 200) begin
            if (ir8) rdy_bad++;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        int cyc, bad;

        repeat (2) @(posedge clk);
        #1;
        check_val("rst_out_valid", 64'(ov32), 64'h0);
        check_val("rst_result", 64'(res32), 64'h0);
        check_val("rst_flags", 64'({z32, v32, n32, c32}), 64'h0);
        check_val("rst_in_ready", 64'(ir32), 64'h1);
        rst = 1'b0;

        // ADD overflow into the sign bit
        op32(3'b000, 32'h7FFF_FFFF, 32'h0000_0001);
        check_val("add_valid", 64'(ov32), 64'h1);
        check_val("add_res", 64'(res32), 64'h8000_0000);
        check_val("add_zvnc", 64'({z32, v32, n32, c32}), 64'b0110);

        // back-to-back SUBs
        op32(3'b001, 32'd5, 32'd5);
        check_val("sub0_valid", 64'(ov32), 64'h1);
        check_val("sub0_res", 64'(res32), 64'h0);
        check_val("sub0_zvnc", 64'({z32, v32, n32, c32}), 64'b1001);
        op32(3'b001, 32'd3, 32'd5);
        check_val("sub1_valid", 64'(ov32), 64'h1);
        check_val("sub1_res", 64'(res32), 64'hFFFF_FFFE);
        check_val("sub1_zvnc", 64'({z32, v32, n32, c32}), 64'b0010);
        @(posedge clk); #1;
        check_val("sub_drained", 64'(ov32), 64'h0);

        // MUL with product exactly 2^32
        op32(3'b110, 32'h0001_0000, 32'h0001_0000);
        wait_out32(cyc, bad);
        check_val("mul_latency", 64'(cyc), 64'd32);
        check_val("mul_ready_low", 64'(bad), 64'd0);
        check_val("mul_res", 64'(res32), 64'h0);
        check_val("mul_zvnc", 64'({z32, v32, n32, c32}), 64'b1001);
        op32(3'b110, 32'd7, 32'd6);
        wait_out32(cyc, bad);
        check_val("mul76_latency", 64'(cyc), 64'd32);
        check_val("mul76_res", 64'(res32), 64'd42);
        check_val("mul76_zvnc", 64'({z32, v32, n32, c32}), 64'b0000);

        // backpressure: result held, pending op not taken until out_ready
        @(posedge clk); #1;
        ordy32 = 1'b0;
        op32(3'b000, 32'd1, 32'd2);
        check_val("bp_valid", 64'(ov32), 64'h1);
        check_val("bp_res", 64'(res32), 64'd3);
        iv32 = 1'b1; a32 = 32'hF0F0_F0F0; b32 = 32'hFF00_FF00; f32 = 3'b010;
        #1;
        check_val("bp_in_ready", 64'(ir32), 64'h0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (ir32 || !ov32 || res32 !== 32'd3) bad++;
            @(posedge clk); #1;
        end
        check_val("bp_hold_cycles", 64'(bad), 64'd0);
        ordy32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        check_val("bp_and_valid", 64'(ov32), 64'h1);
        check_val("bp_and_res", 64'(res32), 64'hF000_F000);
        check_val("bp_and_zvnc", 64'({z32, v32, n32, c32}), 64'b0010);

        // reset during MUL_RUN cycle 10
        op32(3'b110, 32'd3, 32'd5);
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("rmul_valid", 64'(ov32), 64'h0);
        check_val("rmul_ready", 64'(ir32), 64'h1);
        check_val("rmul_res", 64'(res32), 64'h0);
        check_val("rmul_flags", 64'({z32, v32, n32, c32}), 64'h0);
        bad = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ov32) bad++;
        end
        check_val("rmul_no_result", 64'(bad), 64'd0);

        // WIDTH=8 instance
        op8(3'b101, 8'h80, 8'h01);
        check_val("slt8_valid", 64'(ov8), 64'h1);
        check_val("slt8_res", 64'(res8), 64'h01);
        check_val("slt8_zvnc", 64'({z8, v8, n8, c8}), 64'b0000);
        op8(3'b111, 8'h0F, 8'hF0);
        check_val("nor8_res", 64'(res8), 64'h00);
        check_val("nor8_zvnc", 64'({z8, v8, n8, c8}), 64'b1000);
        op8(3'b110, 8'h10, 8'h10);
        wait_out8(cyc, bad);
        check_val("mul8_latency", 64'(cyc), 64'd8);
        check_val("mul8_ready_low", 64'(bad), 64'd0);
        check_val("mul8_res", 64'(res8), 64'h00);
        check_val("mul8_zvnc", 64'({z8, v8, n8, c8}), 64'b1001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
